// File: rtl/ec_scalar_ctrl.sv
// ec_scalar_ctrl: scalar-multiplication sequencer for k*G on y^2=x^3+2x+2 mod 17.
// The scalar is first reduced modulo the group order. A residue of zero gives
// the point at infinity directly. Otherwise the external point adder is reset
// and allowed to step through G, 2G, ... until the k-th multiple is captured.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   k_valid/k_ready/k_in  scalar request handshake (k_in sampled at acceptance)
//   adder_reset           reset for the point-adder stage (START and reset only)
//   pt_x_in/pt_y_in       running multiple presented by the point adder
//   res_valid/res_ready   result handshake
//   res_x/res_y/res_inf   result point, zero-extended to DATA_W
//   busy                  high whenever the sequencer is not idle
//
// The state-derived handshake outputs are state decodes masked by reset, so
// reset forces their reset values in the same cycle and releases them in the
// first cycle after it drops.
module ec_scalar_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ORDER  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              k_valid,
  output logic              k_ready,
  input  logic [7:0]        k_in,
  output logic              adder_reset,
  input  logic [DATA_W-1:0] pt_x_in,
  input  logic [DATA_W-1:0] pt_y_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_x,
  output logic [DATA_W-1:0] res_y,
  output logic              res_inf,
  output logic              busy
);

  localparam int unsigned K_W = 8;
  localparam logic [K_W-1:0] ORDER_K = K_W'(ORDER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_START,
    S_STEP,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_work_q, k_work_d;
  logic [K_W-1:0]      step_cnt_q, step_cnt_d;
  logic [DATA_W-1:0]   res_x_q, res_x_d;
  logic [DATA_W-1:0]   res_y_q, res_y_d;
  logic                res_inf_q, res_inf_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_work_q   <= '0;
      step_cnt_q <= '0;
      res_x_q    <= '0;
      res_y_q    <= '0;
      res_inf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_work_q   <= k_work_d;
      step_cnt_q <= step_cnt_d;
      res_x_q    <= res_x_d;
      res_y_q    <= res_y_d;
      res_inf_q  <= res_inf_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    k_work_d   = k_work_q;
    step_cnt_d = step_cnt_q;
    res_x_d    = res_x_q;
    res_y_d    = res_y_q;
    res_inf_d  = res_inf_q;

    unique case (state_q)
      S_IDLE: begin
        if (k_valid) begin
          k_work_d   = k_in;
          step_cnt_d = '0;
          state_d    = S_REDUCE;
        end
      end
      S_REDUCE: begin
        // One subtraction per cycle; the residue is final once below ORDER.
        if (k_work_q >= ORDER_K) begin
          k_work_d = k_work_q - ORDER_K;
        end else if (k_work_q == '0) begin
          res_x_d   = '0;
          res_y_d   = '0;
          res_inf_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        step_cnt_d = '0;
        state_d    = S_STEP;
      end
      S_STEP: begin
        // The adder presents (step_cnt+1)*G, so step k_work-1 holds k*G.
        if (step_cnt_q == k_work_q - K_W'(1)) begin
          res_x_d   = pt_x_in;
          res_y_d   = pt_y_in;
          res_inf_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          step_cnt_d = step_cnt_q + K_W'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs.
  assign k_ready     = ~reset & (state_q == S_IDLE);
  assign busy        = ~reset & (state_q != S_IDLE);
  assign res_valid   = ~reset & (state_q == S_DONE);
  assign adder_reset =  reset | (state_q == S_START);
  assign res_x       = reset ? '0   : res_x_q;
  assign res_y       = reset ? '0   : res_y_q;
  assign res_inf     = reset ? 1'b0 : res_inf_q;

endmodule

// File: tb/tb_ec_scalar_ctrl.sv
// Self-checking bench for ec_scalar_ctrl with a behavioural point-adder model.
module tb_ec_scalar_ctrl;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ORDER  = 19;

  logic              clk = 1'b0;
  logic              reset;
  logic              k_valid;
  logic              k_ready;
  logic [7:0]        k_in;
  logic              adder_reset;
  logic [DATA_W-1:0] pt_x_in;
  logic [DATA_W-1:0] pt_y_in;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_x;
  logic [DATA_W-1:0] res_y;
  logic              res_inf;
  logic              busy;

  int n_checks = 0;
  int n_err    = 0;
  int ar_cnt   = 0;
  bit rdy_tie  = 1'b0;

  always #5 clk = ~clk;

  ec_scalar_ctrl #(.DATA_W(DATA_W), .ORDER(ORDER)) dut (
    .clk(clk), .reset(reset),
    .k_valid(k_valid), .k_ready(k_ready), .k_in(k_in),
    .adder_reset(adder_reset), .pt_x_in(pt_x_in), .pt_y_in(pt_y_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_inf(res_inf), .busy(busy)
  );

  // Multiples m*G of G=(5,1); index 0 stands for the point at infinity.
  logic [7:0] tx [ORDER];
  logic [7:0] ty [ORDER];
  initial begin
    tx[0]  = 0;  ty[0]  = 0;
    tx[1]  = 5;  ty[1]  = 1;
    tx[2]  = 6;  ty[2]  = 3;
    tx[3]  = 10; ty[3]  = 6;
    tx[4]  = 3;  ty[4]  = 1;
    tx[5]  = 9;  ty[5]  = 16;
    tx[6]  = 16; ty[6]  = 13;
    tx[7]  = 0;  ty[7]  = 6;
    tx[8]  = 13; ty[8]  = 7;
    tx[9]  = 7;  ty[9]  = 6;
    tx[10] = 7;  ty[10] = 11;
    tx[11] = 13; ty[11] = 10;
    tx[12] = 0;  ty[12] = 11;
    tx[13] = 16; ty[13] = 4;
    tx[14] = 9;  ty[14] = 1;
    tx[15] = 3;  ty[15] = 16;
    tx[16] = 10; ty[16] = 11;
    tx[17] = 6;  ty[17] = 14;
    tx[18] = 5;  ty[18] = 16;
  end

  // Point adder: reset loads G, each following cycle adds G.
  int m = 0;
  always @(posedge clk) begin
    if (adder_reset) m <= 1;
    else             m <= (m + 1) % ORDER;
  end
  assign pt_x_in = DATA_W'(tx[m]);
  assign pt_y_in = DATA_W'(ty[m]);

  // Cycles with adder_reset asserted outside of reset.
  always @(negedge clk) begin
    if (!reset && adder_reset) ar_cnt <= ar_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: residue r=k mod n; r==0 is infinity, else r*G, with the latency rule.
  function automatic void ref_model(input int k, output int x, output int y,
                                    output bit inf, output int lat);
    int r, q;
    r = k % ORDER;
    q = k / ORDER;
    inf = (r == 0);
    x = inf ? 0 : int'(tx[r]);
    y = inf ? 0 : int'(ty[r]);
    lat = inf ? q + 2 : q + r + 3;
  endfunction

  // Counts cycles from the acceptance edge to the first res_valid cycle.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 400);
  endtask

  task automatic do_req(input int k, input int ex, input int ey, input bit einf,
                        input int elat, input int hold);
    int lat, ar0, w;
    logic [DATA_W-1:0] hx, hy;
    ar0 = ar_cnt;
    @(negedge clk);
    k_valid = 1'b1;
    k_in    = 8'(k);
    w = 0;
    while (!k_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("k_ready_wait", 64'(k_ready), 64'(1));
    @(posedge clk);
    #1;
    k_valid = 1'b0;
    k_in    = 8'($urandom);
    wait_valid(lat);
    chk($sformatf("latency k=%0d", k), 64'(lat), 64'(elat));
    chk($sformatf("res_x k=%0d", k), res_x, 64'(ex));
    chk($sformatf("res_y k=%0d", k), res_y, 64'(ey));
    chk($sformatf("res_inf k=%0d", k), 64'(res_inf), 64'(einf));
    chk($sformatf("adder_reset_cycles k=%0d", k), 64'(ar_cnt - ar0), einf ? 64'(0) : 64'(1));
    hx = res_x;
    hy = res_y;
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      @(negedge clk);
      if (res_valid !== 1'b1 || res_x !== hx || res_y !== hy || k_ready !== 1'b0)
        chk($sformatf("hold k=%0d", k), {res_valid, k_ready, res_x[31:0] ^ hx[31:0]},
            {1'b1, 1'b0, 32'd0});
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = rdy_tie;
  endtask

  typedef struct {
    int k;
    int x;
    int y;
    bit inf;
    int lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ex, ey, el, lat, kr;
    bit ei;
    vecs[0] = '{2,   6,  3,  1'b0, 5};
    vecs[1] = '{21,  6,  3,  1'b0, 6};
    vecs[2] = '{4,   3,  1,  1'b0, 7};
    vecs[3] = '{10,  7,  11, 1'b0, 13};
    vecs[4] = '{0,   0,  0,  1'b1, 2};
    vecs[5] = '{19,  0,  0,  1'b1, 3};
    vecs[6] = '{255, 13, 7,  1'b0, 24};
    vecs[7] = '{18,  5,  16, 1'b0, 21};
    vecs[8] = '{38,  0,  0,  1'b1, 4};

    reset     = 1'b1;
    k_valid   = 1'b0;
    k_in      = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid",   64'(res_valid),   64'(0));
    chk("rst_k_ready",     64'(k_ready),     64'(0));
    chk("rst_busy",        64'(busy),        64'(0));
    chk("rst_adder_reset", 64'(adder_reset), 64'(1));
    chk("rst_res_x",       res_x,            64'(0));
    chk("rst_res_inf",     64'(res_inf),     64'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_k_ready",     64'(k_ready),     64'(1));
    chk("post_rst_adder_reset", 64'(adder_reset), 64'(0));

    // Directed vectors.
    for (int i = 0; i < 9; i++)
      do_req(vecs[i].k, vecs[i].x, vecs[i].y, vecs[i].inf, vecs[i].lat, i % 3);

    // Result held in DONE while a new request waits.
    @(negedge clk);
    k_valid = 1'b1;
    k_in    = 8'd4;
    @(posedge clk);
    #1;
    k_valid = 1'b0;
    wait_valid(lat);
    chk("done_lat", 64'(lat), 64'(7));
    k_valid = 1'b1;
    k_in    = 8'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("done_hold_valid", 64'(res_valid), 64'(1));
      chk("done_hold_ready", 64'(k_ready),   64'(0));
      chk("done_hold_xy",    {res_x[31:0], res_y[31:0]}, {32'd3, 32'd1});
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("after_hs_idle_ready", 64'(k_ready), 64'(1));
    chk("after_hs_not_busy",   64'(busy),    64'(0));
    @(posedge clk);
    #1;
    k_valid = 1'b0;
    chk("accept_next_busy", 64'(busy), 64'(1));
    wait_valid(lat);
    chk("queued_lat", 64'(lat), 64'(5));
    chk("queued_xy", {res_x[31:0], res_y[31:0]}, {32'd6, 32'd3});
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;

    // Reset pulse in the middle of STEP.
    @(negedge clk);
    k_valid = 1'b1;
    k_in    = 8'd9;
    @(posedge clk);
    #1;
    k_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midstep_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("midrst_adder_reset", 64'(adder_reset), 64'(1));
    chk("midrst_k_ready",     64'(k_ready),     64'(0));
    chk("midrst_busy",        64'(busy),        64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postrst_k_ready",   64'(k_ready),   64'(1));
    chk("postrst_res_valid", 64'(res_valid), 64'(0));
    chk("postrst_busy",      64'(busy),      64'(0));
    do_req(1, 5, 1, 1'b0, 4, 0);

    // Back-to-back with res_ready tied high.
    rdy_tie   = 1'b1;
    res_ready = 1'b1;
    do_req(1, 5, 1,  1'b0, 4, 0);
    do_req(2, 6, 3,  1'b0, 5, 0);
    do_req(3, 10, 6, 1'b0, 6, 0);
    rdy_tie   = 1'b0;
    res_ready = 1'b0;

    // Randomized scalars against the reference model.
    for (int i = 0; i < 30; i++) begin
      kr = int'($urandom_range(0, 255));
      ref_model(kr, ex, ey, ei, el);
      do_req(kr, ex, ey, ei, el, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
